// File: rtl/frame_feeder.sv
// -----------------------------------------------------------------------------
// frame_feeder
//
// Streams one frame of 24-bit pixels from a frame memory into a downstream
// pixel FIFO. Each start request reads IMG_WIDTH*IMG_HEIGHT words in row-major
// order and writes them to the FIFO in the same order. A one-entry skid
// register holds a read return that arrives while the FIFO is full, so no
// pixel is dropped or duplicated.
//
// Ports
//   clock        : single clock, all state updates on the rising edge
//   reset        : asynchronous, active-low reset (low = in reset)
//   start        : one-cycle request to stream a frame (ignored while busy)
//   busy         : high from the cycle after an accepted start until done
//   done         : one-cycle pulse in the cycle the last pixel is written
//   mem_rd_en    : frame-memory read strobe
//   mem_addr     : frame-memory read address (row*IMG_WIDTH+col)
//   mem_rdata    : read data, valid exactly one cycle after mem_rd_en
//   out_full     : downstream FIFO full flag
//   out_wr_en    : downstream FIFO write strobe
//   out_din      : pixel {R,G,B}, bits 23:16 = R
//   frame_count  : frames completed since reset, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module frame_feeder #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [23:0]           mem_rdata,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [23:0]           out_din,
    output logic [15:0]           frame_count
);

    localparam int PIX_TOTAL_I = IMG_WIDTH * IMG_HEIGHT;
    // One extra bit so the read counter can hold the full pixel count even
    // when the frame exactly fills the address space.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(PIX_TOTAL_I);
    localparam logic [CNT_W-1:0] LAST_RD   = CNT_W'(PIX_TOTAL_I - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] rd_cnt;
    logic             rvalid;
    logic             skid_valid;
    logic [23:0]      skid_data;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    logic issue;
    logic write_skid;
    logic write_direct;
    logic capture;
    logic last_write;
    logic accept;

    // State register. Reset drops straight back to IDLE, which abandons any
    // frame in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. RUN ends once the final address has been issued;
    // DRAIN ends on the final write. A start seen outside IDLE, including
    // the done cycle itself, is simply not looked at.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (issue && (rd_cnt == LAST_RD)) next_state = DRAIN;
            DRAIN:   if (last_write) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output and handshake logic. A read is only issued when the returning
    // word is guaranteed a home: the FIFO is not full now and the skid
    // register is empty. The skid register always drains before a direct
    // write so ordering is preserved. out_din only passes mem_rdata when the
    // registered rvalid says the data is real.
    always_comb begin
        issue        = (state == RUN) && !out_full && !skid_valid && (rd_cnt < PIX_TOTAL);
        write_skid   = skid_valid && !out_full;
        write_direct = rvalid && !out_full && !skid_valid;
        capture      = rvalid && !write_direct;
        last_write   = (write_skid || write_direct) && (row == ROW_LAST) && (col == COL_LAST);
        accept       = (state == IDLE) && start;

        busy      = (state != IDLE);
        done      = (state == DRAIN) && last_write;
        mem_rd_en = issue;
        out_wr_en = write_skid || write_direct;
        out_din   = 24'h0;
        if (write_skid) begin
            out_din = skid_data;
        end else if (write_direct) begin
            out_din = mem_rdata;
        end
    end

    // Read side: counter of issued reads, the address presented to memory,
    // and the one-cycle-delayed valid that marks mem_rdata as meaningful.
    // The address returns to 0 after the last read so it never points past
    // the end of the frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt   <= '0;
            mem_addr <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= issue;
            if (accept) begin
                rd_cnt   <= '0;
                mem_addr <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
                if (rd_cnt == LAST_RD) begin
                    mem_addr <= '0;
                end else begin
                    mem_addr <= mem_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Skid register: catches a read return the FIFO cannot take this cycle
    // and empties as soon as the FIFO has room.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_valid <= 1'b0;
            skid_data  <= 24'h0;
        end else if (capture) begin
            skid_valid <= 1'b1;
            skid_data  <= mem_rdata;
        end else if (write_skid) begin
            skid_valid <= 1'b0;
        end
    end

    // Row/column of the next pixel to be written. They also tell us which
    // write is the last one of the frame, and both fall back to 0 there.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (out_wr_en) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row <= '0;
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Completed-frame counter, bumped on the done pulse and free to wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_count <= 16'h0;
        end else if (done) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule
